vec_exec_sequencer: RTL and testbench
=====================================

# vec_exec_sequencer

Multi-cycle execution sequencer that consumes the per-instruction control fields produced by the instruction decoder and steps each operation across the 16 vector elements. It handshakes with fetch/decode, iterates an element counter for `cycle_count + 1` cycles, and emits per-element register-file write strobes, memory address and read/write strobes, and a completion pulse. It sits between decode and the vector/scalar register files and data memory.

## Interface
- No parameters. Element count is fixed at 16; the memory address width is fixed at 16.
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `instr_valid`  in  1  decoded instruction fields are valid this cycle
- `instr_ready`  out  1  sequencer is idle and accepts the instruction
- `functype`  in  4  opcode: 0 VADD, 1 VDOT, 2 SMUL, 3 SST, 4 VLD, 5 VST, 6 SLL, 7 SLH, 8 J, 15 NOP
- `cycle_count`  in  5  last counter value: 0, 15 or 16
- `v_en`, `s_en`  in  1 each  vector / scalar destination write enables from decode
- `dst_addr`  in  3  destination register
- `offset`  in  6  memory offset, two's complement
- `scalar_base`  in  16  base register value, sampled at accept
- `elem_idx`  out  4  current element index
- `mem_addr`  out  16  memory address
- `mem_re`, `mem_we`  out  1 each  data memory read / write strobes
- `vrf_we`  out  1  vector register file element write
- `vrf_elem`  out  4  element index being written
- `srf_we`  out  1  scalar register file write
- `rf_waddr`  out  3  latched `dst_addr`
- `pc_load`  out  1  jump strobe to fetch
- `busy`  out  1  equals `~instr_ready`
- `done`  out  1  one-cycle completion pulse

## Operation
- The state machine has three states.
  - **IDLE**: `instr_ready` = 1. On `instr_valid`, latch `functype`, `cycle_count`, `v_en`, `s_en`, `dst_addr`, `offset` and `scalar_base`. Go to SINGLE if `cycle_count` = 0, otherwise go to RUN with `cnt` = 0.
  - **SINGLE**: active for one cycle with `done` = 1.
    - SLL/SLH: `srf_we` = `s_en`.
    - J: `pc_load` = 1.
    - SST: `mem_we` = 1 and `mem_addr` = base + sext(offset).
    - NOP and undefined opcodes 9–14: no strobes.
    - Next state is IDLE.
  - **RUN**: `cnt` increments each cycle. When `cnt` = latched `cycle_count`, the next state is DONE.
    - VADD/SMUL: `vrf_we` = 1 and `vrf_elem` = `cnt`.
    - VST: `mem_we` = 1.
    - VLD: `mem_re` = 1 while `cnt` ≤ 15. `vrf_we` = 1 while `cnt` ≥ 1, with `vrf_elem` = `cnt` − 1; this covers the one-cycle memory read latency.
    - VDOT: no strobes in RUN.
- **DONE**: active for one cycle with `done` = 1. VDOT asserts `srf_we` here. Next state is IDLE.
- Address arithmetic: `mem_addr` = `scalar_base` + sign-extended `offset` + `cnt[3:0]`, computed modulo 2^16 with silent wrap.
- `elem_idx` = `cnt[3:0]`. `rf_waddr` = latched `dst_addr`.
- Outputs are Moore decodes of state, `cnt` and the latched fields. Decode inputs are ignored whenever the sequencer is not in IDLE.

## Timing
- Accept happens on the edge that ends an IDLE cycle with `instr_valid` = 1. Call that cycle 0.
- For `cycle_count` = N > 0: RUN occupies cycles 1..N+1, DONE is cycle N+2, and `instr_ready` returns to 1 in cycle N+3.
- For N = 0: SINGLE is cycle 1 and `instr_ready` = 1 in cycle 2.
- Back-to-back instructions: the earliest next accept is in the first cycle after DONE or SINGLE. Fetch must hold `instr_valid` and the decoded fields stable while `instr_ready` = 0.
- Reset values: state IDLE, `cnt` 0, all latches 0, and every output 0 except `instr_ready` = 1.
- Asserting reset mid-RUN drops all strobes immediately (asynchronously). No `done` is produced, and the next accept is possible in the first cycle after `rst_n` rises.

## Structure
- Shared package `vec_pkg` holds:
  - the opcode localparams (VADD..J, NOP),
  - `NUM_ELEM` = 16,
  - the sequencer state enum {IDLE, SINGLE, RUN, DONE}.
- One sub-module, `vec_addr_gen`: a combinational adder computing base + sext(offset) + index → 16-bit address. It is reusable by the scalar load/store path.

## Test plan
- **VADD**, dst 3, `cycle_count` 15 → `vrf_we` in cycles 1–16 with `vrf_elem` 0..15 and `rf_waddr` 3; `done` in cycle 17; `instr_ready` = 0 for cycles 1–17.
- **VLD**, base 0x0100, offset 0x3F (−1), `cycle_count` 16 → `mem_re` in cycles 1–16 with addresses 0x00FF..0x010E; `vrf_we` in cycles 2–17 with elements 0..15; `done` in cycle 18.
- **VST**, base 0xFFF8, offset 4 → `mem_we` for 16 cycles with addresses 0xFFFC..0xFFFF, then 0x0000..0x000B (wrap).
- **SLL** dst 5, then **J** back-to-back → `srf_we` and `done` in cycle 1; J accepted in cycle 2; `pc_load` in cycle 3.
- **VDOT** dst 2, `cycle_count` 15 → no `vrf_we` or `mem_*` strobes; a single `srf_we` with `rf_waddr` 2 in cycle 17, coincident with `done`.
- **Reset mid-operation**: assert `rst_n` = 0 during VADD at `cnt` 7 → `vrf_we` drops in the same cycle and no `done` is produced; after release, `instr_ready` = 1 and a new SMUL completes normally.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector execution path: opcodes, element count and
// the sequencer state encoding.
package vec_pkg;
   localparam logic [3:0] OP_VADD = 4'd0;
   localparam logic [3:0] OP_VDOT = 4'd1;
   localparam logic [3:0] OP_SMUL = 4'd2;
   localparam logic [3:0] OP_SST  = 4'd3;
   localparam logic [3:0] OP_VLD  = 4'd4;
   localparam logic [3:0] OP_VST  = 4'd5;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SLH  = 4'd7;
   localparam logic [3:0] OP_J    = 4'd8;
   localparam logic [3:0] OP_NOP  = 4'd15;

   localparam int NUM_ELEM = 16;
   localparam int ADDR_W   = 16;

   typedef enum logic [1:0] {IDLE, SINGLE, RUN, DONE} seq_state_t;
endpackage

// File: rtl/vec_addr_gen.sv
// Memory address generator: base + sign-extended 6-bit offset + element index,
// wrapping modulo 2^16. Shared with the scalar load/store path.
module vec_addr_gen
   import vec_pkg::*;
(
   input  logic [ADDR_W-1:0] base,
   input  logic [5:0]        offset,
   input  logic [3:0]        idx,
   output logic [ADDR_W-1:0] addr
);
   assign addr = base + {{(ADDR_W-6){offset[5]}}, offset} + {{(ADDR_W-4){1'b0}}, idx};
endmodule

// File: rtl/vec_exec_sequencer.sv
// Steps a decoded instruction across the 16 vector elements, producing
// per-element register-file / memory strobes and a completion pulse.
module vec_exec_sequencer
   import vec_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        functype,
   input  logic [4:0]        cycle_count,
   input  logic              v_en,
   input  logic              s_en,
   input  logic [2:0]        dst_addr,
   input  logic [5:0]        offset,
   input  logic [ADDR_W-1:0] scalar_base,
   output logic [3:0]        elem_idx,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic              vrf_we,
   output logic [3:0]        vrf_elem,
   output logic              srf_we,
   output logic [2:0]        rf_waddr,
   output logic              pc_load,
   output logic              busy,
   output logic              done
);
   seq_state_t        state;
   logic [4:0]        cnt;
   logic [4:0]        cc_q;
   logic [3:0]        ft_q;
   logic              v_en_q;
   logic              s_en_q;
   logic [2:0]        dst_q;
   logic [5:0]        off_q;
   logic [ADDR_W-1:0] base_q;
   logic [4:0]        cnt_m1;
   logic              unused_v_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         cc_q   <= '0;
         ft_q   <= '0;
         v_en_q <= 1'b0;
         s_en_q <= 1'b0;
         dst_q  <= '0;
         off_q  <= '0;
         base_q <= '0;
      end else begin
         case (state)
            IDLE: if (instr_valid) begin
               ft_q   <= functype;
               cc_q   <= cycle_count;
               v_en_q <= v_en;
               s_en_q <= s_en;
               dst_q  <= dst_addr;
               off_q  <= offset;
               base_q <= scalar_base;
               cnt    <= '0;
               state  <= (cycle_count == 5'd0) ? SINGLE : RUN;
            end
            SINGLE: state <= IDLE;
            RUN: begin
               if (cnt == cc_q) state <= DONE;
               else             cnt   <= cnt + 5'd1;
            end
            DONE: begin
               cnt   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Vector strobes are opcode-driven; v_en is held only alongside the other fields.
   assign unused_v_en = v_en_q;

   vec_addr_gen u_addr_gen (
      .base   (base_q),
      .offset (off_q),
      .idx    (cnt[3:0]),
      .addr   (mem_addr)
   );

   assign cnt_m1      = cnt - 5'd1;
   assign elem_idx    = cnt[3:0];
   assign rf_waddr    = dst_q;
   assign instr_ready = (state == IDLE);
   assign busy        = (state != IDLE);

   always_comb begin
      mem_re   = 1'b0;
      mem_we   = 1'b0;
      vrf_we   = 1'b0;
      vrf_elem = '0;
      srf_we   = 1'b0;
      pc_load  = 1'b0;
      done     = 1'b0;
      case (state)
         SINGLE: begin
            done = 1'b1;
            case (ft_q)
               OP_SLL, OP_SLH: srf_we  = s_en_q;
               OP_J:           pc_load = 1'b1;
               OP_SST:         mem_we  = 1'b1;
               default: ;
            endcase
         end
         RUN: begin
            case (ft_q)
               OP_VADD, OP_SMUL: begin
                  vrf_we   = 1'b1;
                  vrf_elem = cnt[3:0];
               end
               OP_VST: mem_we = 1'b1;
               // Load data returns one cycle after the read, so writeback trails by one element.
               OP_VLD: begin
                  mem_re = ~cnt[4];
                  if (cnt != 5'd0) begin
                     vrf_we   = 1'b1;
                     vrf_elem = cnt_m1[3:0];
                  end
               end
               default: ;
            endcase
         end
         DONE: begin
            done   = 1'b1;
            srf_we = (ft_q == OP_VDOT);
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_vec_exec_sequencer.sv
// Self-checking bench for vec_exec_sequencer: directed table, back-to-back and
// reset corner cases, and random instructions against a per-element model.
module tb_vec_exec_sequencer;
   localparam logic [3:0] F_VADD = 4'd0, F_VDOT = 4'd1, F_SMUL = 4'd2, F_SST = 4'd3,
                          F_VLD = 4'd4, F_VST = 4'd5, F_SLL = 4'd6, F_SLH = 4'd7,
                          F_J = 4'd8, F_NOP = 4'd15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  functype;
   logic [4:0]  cycle_count;
   logic        v_en, s_en;
   logic [2:0]  dst_addr;
   logic [5:0]  offset;
   logic [15:0] scalar_base;
   logic [3:0]  elem_idx;
   logic [15:0] mem_addr;
   logic        mem_re, mem_we, vrf_we;
   logic [3:0]  vrf_elem;
   logic        srf_we;
   logic [2:0]  rf_waddr;
   logic        pc_load, busy, done;

   always #5 clk = ~clk;

   vec_exec_sequencer dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .functype(functype), .cycle_count(cycle_count), .v_en(v_en), .s_en(s_en),
      .dst_addr(dst_addr), .offset(offset), .scalar_base(scalar_base),
      .elem_idx(elem_idx), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
      .vrf_we(vrf_we), .vrf_elem(vrf_elem), .srf_we(srf_we), .rf_waddr(rf_waddr),
      .pc_load(pc_load), .busy(busy), .done(done)
   );

   typedef struct packed {
      logic [3:0] ft; logic [4:0] cc; logic v_en; logic s_en;
      logic [2:0] dst; logic [5:0] off; logic [15:0] base;
   } instr_t;

   typedef struct packed {
      logic ready; logic busy; logic done; logic vrf_we; logic [3:0] vrf_elem;
      logic srf_we; logic [2:0] rf_waddr; logic mem_re; logic mem_we;
      logic [15:0] mem_addr; logic pc_load; logic [3:0] elem_idx;
   } obs_t;

   typedef struct packed {
      logic [7:0] len; logic [7:0] vrf; logic [7:0] mre; logic [7:0] mwe;
      logic [7:0] srf; logic [7:0] pcl; logic [15:0] af; logic [15:0] al;
   } sum_t;

   typedef struct packed { instr_t i; sum_t s; } vec_t;

   int   total = 0;
   int   bad   = 0;
   sum_t got;
   obs_t RST_OBS;
   vec_t tbl[$];

   function automatic instr_t mk_i(logic [3:0] ft, logic [4:0] cc, logic s, logic [2:0] d,
                                   logic [5:0] o, logic [15:0] b);
      instr_t r;
      r.ft = ft; r.cc = cc; r.v_en = 1'b1; r.s_en = s; r.dst = d; r.off = o; r.base = b;
      return r;
   endfunction

   function automatic sum_t mk_s(int len, int v, int mr, int mw, int s, int p,
                                 logic [15:0] af, logic [15:0] al);
      sum_t r;
      r.len = 8'(len); r.vrf = 8'(v); r.mre = 8'(mr); r.mwe = 8'(mw);
      r.srf = 8'(s); r.pcl = 8'(p); r.af = af; r.al = al;
      return r;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.ready = instr_ready; o.busy = busy; o.done = done; o.vrf_we = vrf_we;
      o.vrf_elem = vrf_elem; o.srf_we = srf_we; o.rf_waddr = rf_waddr;
      o.mem_re = mem_re; o.mem_we = mem_we; o.mem_addr = mem_addr;
      o.pc_load = pc_load; o.elem_idx = elem_idx;
      return o;
   endfunction

   // Expected outputs in cycle k (1-based) after accepting instruction i.
   function automatic obs_t mdl(instr_t i, int k);
      obs_t e; int len, el; logic [15:0] a0;
      e = '0;
      len = (i.cc == 5'd0) ? 1 : int'(i.cc) + 2;
      el  = k - 1;
      a0  = i.base + {{10{i.off[5]}}, i.off};
      e.busy = 1'b1; e.rf_waddr = i.dst; e.done = (k == len);
      if (i.cc == 5'd0) begin
         if ((i.ft == F_SLL || i.ft == F_SLH) && i.s_en) e.srf_we = 1'b1;
         if (i.ft == F_J) e.pc_load = 1'b1;
         if (i.ft == F_SST) begin e.mem_we = 1'b1; e.mem_addr = a0; end
      end else if (k < len) begin
         e.elem_idx = 4'(el % 16);
         if (i.ft == F_VADD || i.ft == F_SMUL) begin e.vrf_we = 1'b1; e.vrf_elem = 4'(el); end
         if (i.ft == F_VST) begin e.mem_we = 1'b1; e.mem_addr = a0 + 16'(el % 16); end
         if (i.ft == F_VLD) begin
            if (el <= 15) begin e.mem_re = 1'b1; e.mem_addr = a0 + 16'(el); end
            if (el >= 1) begin e.vrf_we = 1'b1; e.vrf_elem = 4'(el - 1); end
         end
      end else if (i.ft == F_VDOT) e.srf_we = 1'b1;
      return e;
   endfunction

   function automatic obs_t mask(obs_t o, obs_t e, logic run);
      if (!(e.mem_re || e.mem_we)) o.mem_addr = '0;
      if (!e.vrf_we) o.vrf_elem = '0;
      if (!run) o.elem_idx = '0;
      return o;
   endfunction

   function automatic obs_t idle_view(obs_t o);
      o.mem_addr = '0; o.vrf_elem = '0; o.rf_waddr = '0; o.elem_idx = '0;
      return o;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_rand();
      instr_valid = 1'($urandom_range(0, 1));
      functype = 4'($urandom); cycle_count = 5'($urandom); v_en = 1'($urandom);
      s_en = 1'($urandom); dst_addr = 3'($urandom); offset = 6'($urandom);
      scalar_base = 16'($urandom);
   endtask

   task automatic drive(input instr_t i);
      instr_valid = 1'b1; functype = i.ft; cycle_count = i.cc; v_en = i.v_en;
      s_en = i.s_en; dst_addr = i.dst; offset = i.off; scalar_base = i.base;
   endtask

   task automatic idle_check(input string name);
      obs_t want;
      want = '0; want.ready = 1'b1;
      check(name, 128'(idle_view(sample())), 128'(want));
   endtask

   // Offer i in the next cycle, then check every cycle until it completes.
   task automatic issue(input instr_t i);
      int len; obs_t e, a;
      len = (i.cc == 5'd0) ? 1 : int'(i.cc) + 2;
      @(negedge clk);
      idle_check("accept_ready");
      drive(i);
      got = '0;
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         drive_rand();
         e = mdl(i, k);
         a = mask(sample(), e, (i.cc != 5'd0) && (k < len));
         check($sformatf("op%0d_cyc%0d", i.ft, k), 128'(a), 128'(e));
         if (a.done) got.len = 8'(k);
         if (a.vrf_we) got.vrf++;
         if (a.mem_re) got.mre++;
         if (a.mem_we) got.mwe++;
         if (a.srf_we) got.srf++;
         if (a.pc_load) got.pcl++;
         if (a.mem_re || a.mem_we) begin
            if (got.mre + got.mwe == 8'd1) got.af = a.mem_addr;
            got.al = a.mem_addr;
         end
      end
   endtask

   initial begin
      instr_t ri; obs_t e;
      RST_OBS = '0; RST_OBS.ready = 1'b1;
      rst_n = 1'b0;
      instr_valid = 1'b0; functype = '0; cycle_count = '0; v_en = 1'b0; s_en = 1'b0;
      dst_addr = '0; offset = '0; scalar_base = '0;
      #12;
      check("reset_state", 128'(sample()), 128'(RST_OBS));
      @(negedge clk); rst_n = 1'b1;

      tbl.push_back({mk_i(F_VADD, 5'd15, 1'b0, 3'd3, 6'd0, 16'h0000),  mk_s(17, 16, 0, 0, 0, 0, 16'h0, 16'h0)});
      tbl.push_back({mk_i(F_VLD, 5'd16, 1'b0, 3'd1, 6'h3F, 16'h0100),  mk_s(18, 16, 16, 0, 0, 0, 16'h00FF, 16'h010E)});
      tbl.push_back({mk_i(F_VST, 5'd15, 1'b0, 3'd0, 6'd4, 16'hFFF8),   mk_s(17, 0, 0, 16, 0, 0, 16'hFFFC, 16'h000B)});
      tbl.push_back({mk_i(F_SLL, 5'd0, 1'b1, 3'd5, 6'd0, 16'h0000),    mk_s(1, 0, 0, 0, 1, 0, 16'h0, 16'h0)});
      tbl.push_back({mk_i(F_J, 5'd0, 1'b0, 3'd0, 6'd0, 16'h0000),      mk_s(1, 0, 0, 0, 0, 1, 16'h0, 16'h0)});
      tbl.push_back({mk_i(F_VDOT, 5'd15, 1'b0, 3'd2, 6'd7, 16'h0040),  mk_s(17, 0, 0, 0, 1, 0, 16'h0, 16'h0)});
      tbl.push_back({mk_i(F_SST, 5'd0, 1'b0, 3'd0, 6'h20, 16'h1234),   mk_s(1, 0, 0, 1, 0, 0, 16'h1214, 16'h1214)});
      tbl.push_back({mk_i(F_NOP, 5'd0, 1'b1, 3'd6, 6'd0, 16'h0000),    mk_s(1, 0, 0, 0, 0, 0, 16'h0, 16'h0)});
      tbl.push_back({mk_i(F_SMUL, 5'd15, 1'b0, 3'd7, 6'd0, 16'h0000),  mk_s(17, 16, 0, 0, 0, 0, 16'h0, 16'h0)});
      tbl.push_back({mk_i(F_SLH, 5'd0, 1'b0, 3'd4, 6'd0, 16'h0000),    mk_s(1, 0, 0, 0, 0, 0, 16'h0, 16'h0)});
      tbl.push_back({mk_i(F_SLH, 5'd0, 1'b1, 3'd4, 6'd0, 16'h0000),    mk_s(1, 0, 0, 0, 1, 0, 16'h0, 16'h0)});
      tbl.push_back({mk_i(4'd12, 5'd0, 1'b1, 3'd1, 6'd0, 16'h0000),    mk_s(1, 0, 0, 0, 0, 0, 16'h0, 16'h0)});

      // Entries run back-to-back, so SLL followed by J covers the earliest re-accept.
      foreach (tbl[n]) begin
         issue(tbl[n].i);
         check($sformatf("summary_%0d", n), 128'(got), 128'(tbl[n].s));
      end

      // Reset while VADD is at element 7: strobes drop without waiting for a clock.
      ri = mk_i(F_VADD, 5'd15, 1'b0, 3'd4, 6'd0, 16'h0000);
      @(negedge clk);
      idle_check("rst_pre_accept");
      drive(ri);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         instr_valid = 1'b0;
      end
      e = mdl(ri, 8);
      check("rst_pre_elem7", 128'(mask(sample(), e, 1'b1)), 128'(e));
      #2 rst_n = 1'b0;
      #1 check("rst_async_drop", 128'(sample()), 128'(RST_OBS));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst_no_done", 128'(sample()), 128'(RST_OBS));
      end
      rst_n = 1'b1;
      issue(mk_i(F_SMUL, 5'd15, 1'b0, 3'd6, 6'd0, 16'h0000));
      check("rst_smul_summary", 128'(got), 128'(mk_s(17, 16, 0, 0, 0, 0, 16'h0, 16'h0)));

      for (int n = 0; n < 40; n++) begin
         ri.ft = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 2))
            0:       ri.cc = 5'd0;
            1:       ri.cc = 5'd15;
            default: ri.cc = 5'd16;
         endcase
         ri.v_en = 1'($urandom); ri.s_en = 1'($urandom); ri.dst = 3'($urandom);
         ri.off = 6'($urandom); ri.base = 16'($urandom);
         issue(ri);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            instr_valid = 1'b0;
            idle_check("rand_gap");
         end
      end

      @(negedge clk);
      instr_valid = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
